// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - ID/WB inputs and EX outputs of the ID->EX pipeline register
interface id_ex_pipe_if #(
    parameter int WORD   = 64,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [4:0]        id_rn;
    logic [4:0]        id_rm;
    logic [4:0]        id_rd;
    logic              id_use_rn;
    logic              id_use_rm;
    logic [WORD-1:0]   id_r_data1;
    logic [WORD-1:0]   id_r_data2;
    logic [WORD-1:0]   id_imm;
    logic [WORD-1:0]   id_pc;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read;
    logic              wb_reg_write;
    logic [4:0]        wb_w_reg;
    logic [WORD-1:0]   wb_w_data;
    logic              flush_i;
    logic              hold_i;
    logic              ex_valid;
    logic [4:0]        ex_rn;
    logic [4:0]        ex_rm;
    logic [4:0]        ex_rd;
    logic [WORD-1:0]   ex_a;
    logic [WORD-1:0]   ex_b;
    logic [WORD-1:0]   ex_imm;
    logic [WORD-1:0]   ex_pc;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm,
               id_r_data1, id_r_data2, id_imm, id_pc, id_ctrl, id_mem_read,
               wb_reg_write, wb_w_reg, wb_w_data, flush_i, hold_i,
        input  ex_valid, ex_rn, ex_rm, ex_rd, ex_a, ex_b, ex_imm, ex_pc,
               ex_ctrl, ex_mem_read, stall_o, stall_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm,
               id_r_data1, id_r_data2, id_imm, id_pc, id_ctrl, id_mem_read,
               wb_reg_write, wb_w_reg, wb_w_data, flush_i, hold_i,
        output ex_valid, ex_rn, ex_rm, ex_rd, ex_a, ex_b, ex_imm, ex_pc,
               ex_ctrl, ex_mem_read, stall_o, stall_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID->EX pipeline register with WB bypass, load-use stall and stall counter
module id_ex_pipe #(
    parameter int WORD   = 64,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    id_ex_pipe_if.slave bus
);
    localparam logic [4:0] XZR = 5'd31;

    logic              ex_valid_q;
    logic [4:0]        ex_rn_q;
    logic [4:0]        ex_rm_q;
    logic [4:0]        ex_rd_q;
    logic [WORD-1:0]   ex_a_q;
    logic [WORD-1:0]   ex_b_q;
    logic [WORD-1:0]   ex_imm_q;
    logic [WORD-1:0]   ex_pc_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic              ex_mem_read_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              hz;
    logic              stall;
    logic [WORD-1:0]   a_nxt;
    logic [WORD-1:0]   b_nxt;

    // Register file writes at the edge, so the value ID reads this cycle is stale
    // when WB targets the same register; XZR reads as zero and is never bypassed.
    always_comb begin
        a_nxt = bus.id_r_data1;
        b_nxt = bus.id_r_data2;
        if (bus.wb_reg_write && (bus.wb_w_reg == bus.id_rn) && (bus.id_rn != XZR)) begin
            a_nxt = bus.wb_w_data;
        end
        if (bus.wb_reg_write && (bus.wb_w_reg == bus.id_rm) && (bus.id_rm != XZR)) begin
            b_nxt = bus.wb_w_data;
        end
    end

    // Load in EX feeding an ID source: hold IF/ID one cycle; a flush overrides any stall.
    always_comb begin
        hz = ex_valid_q && ex_mem_read_q && (ex_rd_q != XZR) && bus.id_valid &&
             ((bus.id_use_rn && (bus.id_rn == ex_rd_q)) ||
              (bus.id_use_rm && (bus.id_rm == ex_rd_q)));
        stall = rst_n && !bus.flush_i && (hz || bus.hold_i);
    end

    // Pipeline register: flush > hold > load-use bubble > capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rn_q       <= '0;
            ex_rm_q       <= '0;
            ex_rd_q       <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_imm_q      <= '0;
            ex_pc_q       <= '0;
            ex_ctrl_q     <= '0;
            ex_mem_read_q <= 1'b0;
        end else if (bus.flush_i || (!bus.hold_i && hz)) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= '0;
            ex_mem_read_q <= 1'b0;
        end else if (!bus.hold_i) begin
            ex_valid_q    <= bus.id_valid;
            ex_rn_q       <= bus.id_rn;
            ex_rm_q       <= bus.id_rm;
            ex_rd_q       <= bus.id_rd;
            ex_a_q        <= a_nxt;
            ex_b_q        <= b_nxt;
            ex_imm_q      <= bus.id_imm;
            ex_pc_q       <= bus.id_pc;
            ex_ctrl_q     <= bus.id_valid ? bus.id_ctrl : '0;
            ex_mem_read_q <= bus.id_valid && bus.id_mem_read;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_rn       = ex_rn_q;
    assign bus.ex_rm       = ex_rm_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_a        = ex_a_q;
    assign bus.ex_b        = ex_b_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.ex_mem_read = ex_mem_read_q;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - directed self-checking bench for id_ex_pipe
module tb_id_ex_pipe;
    localparam int WORD   = 64;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    id_ex_pipe_if #(.WORD(WORD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    id_ex_pipe #(.WORD(WORD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_rn        = 5'd0;
        bus.id_rm        = 5'd0;
        bus.id_rd        = 5'd0;
        bus.id_use_rn    = 1'b0;
        bus.id_use_rm    = 1'b0;
        bus.id_r_data1   = '0;
        bus.id_r_data2   = '0;
        bus.id_imm       = '0;
        bus.id_pc        = '0;
        bus.id_ctrl      = '0;
        bus.id_mem_read  = 1'b0;
        bus.wb_reg_write = 1'b0;
        bus.wb_w_reg     = 5'd0;
        bus.wb_w_data    = '0;
        bus.flush_i      = 1'b0;
        bus.hold_i       = 1'b0;
    endtask

    task automatic instr(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic load, input logic [CTRL_W-1:0] ctrl);
        bus.id_valid    = 1'b1;
        bus.id_rn       = rn;
        bus.id_rm       = rm;
        bus.id_rd       = rd;
        bus.id_use_rn   = 1'b1;
        bus.id_use_rm   = 1'b0;
        bus.id_mem_read = load;
        bus.id_ctrl     = ctrl;
    endtask

    initial begin
        // 1 reset with garbage on every input
        rst_n = 1'b0;
        idle();
        bus.id_valid = 1'b1; bus.id_rd = 5'd9; bus.id_mem_read = 1'b1;
        bus.id_r_data1 = 64'hDEAD; bus.id_imm = 64'hBEEF; bus.id_ctrl = 12'hFFF;
        bus.hold_i = 1'b1;
        #1;
        check("rst_stall_o_comb", bus.stall_o, 0);
        step();
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_ex_ctrl", bus.ex_ctrl, 0);
        check("rst_ex_a", bus.ex_a, 0);
        check("rst_ex_imm", bus.ex_imm, 0);
        check("rst_ex_mem_read", bus.ex_mem_read, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_stall_o", bus.stall_o, 0);
        rst_n = 1'b1;
        idle();

        // 2 pass-through
        instr(5'd1, 5'd7, 5'd4, 1'b0, 12'h005);
        bus.id_r_data1 = 64'h11; bus.id_r_data2 = 64'h22; bus.id_imm = 64'h8; bus.id_pc = 64'h100;
        step();
        check("pt_ex_a", bus.ex_a, 64'h11);
        check("pt_ex_b", bus.ex_b, 64'h22);
        check("pt_ex_imm", bus.ex_imm, 64'h8);
        check("pt_ex_pc", bus.ex_pc, 64'h100);
        check("pt_ex_ctrl", bus.ex_ctrl, 12'h005);
        check("pt_ex_valid", bus.ex_valid, 1);
        check("pt_ex_rn", bus.ex_rn, 1);
        check("pt_ex_rd", bus.ex_rd, 4);

        // 3 WB bypass, then XZR not bypassed
        bus.id_rn = 5'd3; bus.id_r_data1 = 64'hAA;
        bus.wb_reg_write = 1'b1; bus.wb_w_reg = 5'd3; bus.wb_w_data = 64'hBB;
        step();
        check("byp_ex_a", bus.ex_a, 64'hBB);
        check("byp_ex_b_untouched", bus.ex_b, 64'h22);
        bus.id_rn = 5'd31; bus.wb_w_reg = 5'd31;
        step();
        check("byp_xzr_ex_a", bus.ex_a, 64'hAA);
        bus.id_rm = 5'd7; bus.wb_w_reg = 5'd7; bus.wb_reg_write = 1'b0;
        step();
        check("byp_no_we_ex_b", bus.ex_b, 64'h22);

        // 4 load-use: LDUR X2 then ADD reading X2
        instr(5'd1, 5'd0, 5'd2, 1'b1, 12'h003);
        step();
        check("lu_ex_mem_read", bus.ex_mem_read, 1);
        instr(5'd2, 5'd0, 5'd6, 1'b0, 12'h009);
        #1;
        check("lu_stall_o", bus.stall_o, 1);
        step();
        check("lu_bubble_valid", bus.ex_valid, 0);
        check("lu_bubble_ctrl", bus.ex_ctrl, 0);
        check("lu_bubble_mem_read", bus.ex_mem_read, 0);
        check("lu_stall_cnt", bus.stall_cnt, 1);
        check("lu_stall_dropped", bus.stall_o, 0);
        step();
        check("lu_add_valid", bus.ex_valid, 1);
        check("lu_add_ctrl", bus.ex_ctrl, 12'h009);
        check("lu_add_rd", bus.ex_rd, 6);
        check("lu_cnt_after", bus.stall_cnt, 1);

        // load into XZR never stalls
        instr(5'd1, 5'd0, 5'd31, 1'b1, 12'h003);
        step();
        instr(5'd31, 5'd0, 5'd6, 1'b0, 12'h00A);
        #1;
        check("xzr_stall_o", bus.stall_o, 0);
        step();
        check("xzr_ex_ctrl", bus.ex_ctrl, 12'h00A);
        check("xzr_stall_cnt", bus.stall_cnt, 1);

        // hazard on rm source
        instr(5'd1, 5'd0, 5'd5, 1'b1, 12'h003);
        step();
        instr(5'd0, 5'd5, 5'd6, 1'b0, 12'h00B);
        bus.id_use_rn = 1'b0; bus.id_use_rm = 1'b1;
        #1;
        check("rm_stall_o", bus.stall_o, 1);
        step();
        check("rm_bubble_valid", bus.ex_valid, 0);
        check("rm_stall_cnt", bus.stall_cnt, 2);

        // 5 flush beats hazard and hold
        instr(5'd1, 5'd0, 5'd2, 1'b1, 12'h003);
        step();
        instr(5'd2, 5'd0, 5'd6, 1'b0, 12'h009);
        bus.hold_i = 1'b1; bus.flush_i = 1'b1;
        #1;
        check("fl_stall_o", bus.stall_o, 0);
        step();
        check("fl_ex_valid", bus.ex_valid, 0);
        check("fl_ex_ctrl", bus.ex_ctrl, 0);
        check("fl_ex_mem_read", bus.ex_mem_read, 0);
        check("fl_stall_cnt", bus.stall_cnt, 2);
        bus.hold_i = 1'b0; bus.flush_i = 1'b0;

        // invalid ID is captured as a bubble
        bus.id_valid = 1'b0; bus.id_mem_read = 1'b1;
        step();
        check("inv_ex_valid", bus.ex_valid, 0);
        check("inv_ex_ctrl", bus.ex_ctrl, 0);
        check("inv_ex_mem_read", bus.ex_mem_read, 0);

        // 6 hold freezes EX and counts; counter saturates at all ones
        instr(5'd1, 5'd0, 5'd8, 1'b0, 12'h007);
        bus.id_r_data1 = 64'h33;
        step();
        check("hd_pre_ex_a", bus.ex_a, 64'h33);
        instr(5'd4, 5'd0, 5'd9, 1'b1, 12'h0F0);
        bus.id_r_data1 = 64'h44; bus.hold_i = 1'b1;
        #1;
        check("hd_stall_o", bus.stall_o, 1);
        for (int i = 0; i < 3; i++) step();
        check("hd_ex_a", bus.ex_a, 64'h33);
        check("hd_ex_ctrl", bus.ex_ctrl, 12'h007);
        check("hd_ex_rd", bus.ex_rd, 8);
        check("hd_ex_valid", bus.ex_valid, 1);
        check("hd_stall_cnt", bus.stall_cnt, 5);
        for (int i = 0; i < 10; i++) step();
        check("sat_cnt_max", bus.stall_cnt, 15);
        for (int i = 0; i < 3; i++) step();
        check("sat_cnt_hold", bus.stall_cnt, 15);
        bus.hold_i = 1'b0;
        step();
        check("hd_release_ex_a", bus.ex_a, 64'h44);
        check("hd_release_ctrl", bus.ex_ctrl, 12'h0F0);
        check("hd_release_cnt", bus.stall_cnt, 15);

        // reset in the middle of a hold
        bus.hold_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall_o", bus.stall_o, 0);
        step();
        check("mid_rst_cnt", bus.stall_cnt, 0);
        check("mid_rst_ex_valid", bus.ex_valid, 0);
        check("mid_rst_ex_mem_read", bus.ex_mem_read, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
